// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM encoding and default signature geometry.
// Keeps the pattern LFSR and response MISR on the same polynomial.
package bist_pkg;

    typedef logic [1:0] bist_state_t;

    localparam bist_state_t ST_IDLE    = 2'd0;
    localparam bist_state_t ST_COMPACT = 2'd1;
    localparam bist_state_t ST_COMPARE = 2'd2;
    localparam bist_state_t ST_DONE    = 2'd3;

    localparam int          SIG_W_DEF  = 21;
    localparam int          N_IN_DEF   = 3;
    localparam logic [20:0] POLY_DEF   = 21'h000005;
    localparam logic [20:0] GOLDEN_DEF = 21'h000000;

endpackage

// File: rtl/bist_signature_analyzer_misr_core.sv
// Multiple-input signature register: shift with polynomial feedback,
// XOR in the parallel response bits at the low end.
module misr_core
    import bist_pkg::*;
#(
    parameter int               SIG_W = SIG_W_DEF,
    parameter int               N_IN  = N_IN_DEF,
    parameter logic [SIG_W-1:0] POLY  = POLY_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    input  logic [N_IN-1:0]  resp,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] fb;
    logic [SIG_W-1:0] nxt;

    always_comb begin
        fb  = sig[SIG_W-1] ? POLY : '0;
        nxt = {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(resp);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= nxt;
        end
    end

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST response compactor with end-of-test signature compare and
// a held pass/fail verdict.
module bist_signature_analyzer
    import bist_pkg::*;
#(
    parameter int               SIG_W  = SIG_W_DEF,
    parameter int               N_IN   = N_IN_DEF,
    parameter logic [SIG_W-1:0] POLY   = POLY_DEF,
    parameter logic [SIG_W-1:0] GOLDEN = GOLDEN_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             capture_en,
    input  logic [N_IN-1:0]  resp,
    input  logic             finish,
    output logic [SIG_W-1:0] hf,
    output logic             busy,
    output logic             done,
    output logic             pass_fail
);

    bist_state_t state;
    logic        verdict;
    logic        misr_en;

    // start always wins, so it both clears and blocks this cycle's capture
    assign misr_en = (state == ST_COMPACT) && capture_en && !start;

    misr_core #(
        .SIG_W (SIG_W),
        .N_IN  (N_IN),
        .POLY  (POLY)
    ) u_misr (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (start),
        .en   (misr_en),
        .resp (resp),
        .sig  (hf)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            verdict <= 1'b0;
        end else if (start) begin
            state   <= ST_COMPACT;
            verdict <= 1'b0;
        end else begin
            unique case (state)
                ST_COMPACT: begin
                    if (finish) begin
                        state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    verdict <= (hf == GOLDEN);
                    state   <= ST_DONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state == ST_COMPACT) || (state == ST_COMPARE);
    assign done      = (state == ST_DONE);
    assign pass_fail = verdict && done;

endmodule
